// File: rtl/ifetch_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// ifetch_dmem_arbiter
//
// Shares the core's single memory port between the instruction fetch path and
// the load/store unit. At most one memory transaction is outstanding at a time.
//
// Arbitration takes place only while idle:
//   - Data accesses win.
//   - A fairness counter forces one fetch grant after MAX_DATA_BURST
//     consecutive data grants made while a fetch was waiting.
//
// Flush handling:
//   - A fetch flushed before its ack parks in DRAIN. The memory request stays
//     up until the ack arrives, and that ack is then swallowed.
//
// Watchdog:
//   - Aborts any transaction that waits too long for its ack.
//   - A fetch abort returns NOP_INSTR.
//   - A data abort returns an error response.
//   - A drain abort returns nothing.
//   - bus_err_o pulses in the cycle after the abort.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   if_req_i / if_addr_i        fetch request (level) and address
//   if_flush_i                  discard outstanding or pending fetch
//   if_rsp_o / if_rdata_o       fetch response pulse and instruction word
//   d_rd_i / d_wr_i             load / store request (level)
//   d_addr_i, d_wdata_i,
//   d_wstrb_i                   data address, store data, store byte enables
//   d_rsp_o / d_rdata_o /
//   d_err_o                     data response pulse, load data, abort flag
//   m_req_o, m_we_o, m_addr_o,
//   m_wdata_o, m_wstrb_o        registered memory request
//   m_ack_i / m_rdata_i         memory ack with same-cycle read data
//   bus_err_o                   watchdog abort pulse
// ----------------------------------------------------------------------------
module ifetch_dmem_arbiter #(
    parameter int unsigned MAX_DATA_BURST = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic        if_rsp_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_rd_i,
    input  logic        d_wr_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_wstrb_i,
    output logic        d_rsp_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wstrb_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_rdata_i,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [3:0]  BURST_MAX = MAX_DATA_BURST[3:0];
    localparam logic        WD_EN     = (TIMEOUT_CYCLES != 32'd0);
    // The abort fires in the last permitted cycle. That makes the total time
    // spent in the waiting state exactly TIMEOUT_CYCLES cycles.
    localparam logic [31:0] WD_LAST   = (TIMEOUT_CYCLES == 32'd0) ? 32'd0
                                                                  : TIMEOUT_CYCLES - 32'd1;

    state_t      state_r;
    state_t      state_s;
    logic        m_req_r;
    logic        m_we_r;
    logic [31:0] m_addr_r;
    logic [31:0] m_wdata_r;
    logic [3:0]  m_wstrb_r;
    logic [3:0]  burst_r;
    logic [3:0]  burst_s;
    logic [31:0] wd_r;
    logic        bus_err_r;

    logic        fetch_want_s;
    logic        data_want_s;
    logic        grant_data_s;
    logic        grant_fetch_s;
    logic        wd_expire_s;

    logic        if_rsp_s;
    logic [31:0] if_rdata_s;
    logic        d_rsp_s;
    logic        d_err_s;
    logic [31:0] d_rdata_s;

    // Fetches are always word aligned, so the low address bits are dropped.
    logic        if_addr_unused_s;
    assign if_addr_unused_s = ^if_addr_i[1:0];

    // Arbitration, next-state selection and watchdog expiry
    always_comb begin
        fetch_want_s  = if_req_i & ~if_flush_i;
        data_want_s   = d_rd_i | d_wr_i;
        grant_data_s  = 1'b0;
        grant_fetch_s = 1'b0;
        wd_expire_s   = 1'b0;
        state_s       = state_r;

        // An ack in the expiry cycle still counts as a normal completion.
        if (WD_EN && (state_r != ST_IDLE) && (wd_r == WD_LAST) && !m_ack_i) begin
            wd_expire_s = 1'b1;
        end else begin
            wd_expire_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (data_want_s && !((burst_r == BURST_MAX) && fetch_want_s)) begin
                    grant_data_s = 1'b1;
                    state_s      = ST_DATA;
                end else if (fetch_want_s) begin
                    grant_fetch_s = 1'b1;
                    state_s       = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (m_ack_i || wd_expire_s) begin
                    state_s = ST_IDLE;
                end else if (if_flush_i) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DATA: begin
                if (m_ack_i || wd_expire_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_DRAIN: begin
                if (m_ack_i || wd_expire_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Fairness counter: counts data grants that overtook a waiting fetch
    always_comb begin
        burst_s = burst_r;
        if (!if_req_i) begin
            burst_s = 4'd0;
        end else if (grant_fetch_s) begin
            burst_s = 4'd0;
        end else if (grant_data_s && fetch_want_s && (burst_r != BURST_MAX)) begin
            burst_s = burst_r + 4'd1;
        end else begin
            burst_s = burst_r;
        end
    end

    // Response generation, combinational in the ack or abort cycle
    always_comb begin
        if_rsp_s   = 1'b0;
        if_rdata_s = 32'd0;
        d_rsp_s    = 1'b0;
        d_err_s    = 1'b0;
        d_rdata_s  = 32'd0;
        case (state_r)
            ST_FETCH: begin
                // A flush in the completion cycle discards the fetch result.
                if (if_flush_i) begin
                    if_rsp_s = 1'b0;
                end else if (m_ack_i) begin
                    if_rsp_s   = 1'b1;
                    if_rdata_s = m_rdata_i;
                end else if (wd_expire_s) begin
                    if_rsp_s   = 1'b1;
                    if_rdata_s = NOP_INSTR;
                end else begin
                    if_rsp_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (m_ack_i) begin
                    d_rsp_s   = 1'b1;
                    d_rdata_s = m_we_r ? 32'd0 : m_rdata_i;
                end else if (wd_expire_s) begin
                    d_rsp_s = 1'b1;
                    d_err_s = 1'b1;
                end else begin
                    d_rsp_s = 1'b0;
                end
            end
            default: begin
                if_rsp_s = 1'b0;
                d_rsp_s  = 1'b0;
            end
        endcase
    end

    // State, memory request registers, fairness counter, watchdog and error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            m_req_r   <= 1'b0;
            m_we_r    <= 1'b0;
            m_addr_r  <= 32'd0;
            m_wdata_r <= 32'd0;
            m_wstrb_r <= 4'd0;
            burst_r   <= 4'd0;
            wd_r      <= 32'd0;
            bus_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            burst_r   <= burst_s;
            bus_err_r <= wd_expire_s;

            // The watchdog restarts on every state entry and idles at zero.
            if (state_s != state_r) begin
                wd_r <= 32'd0;
            end else if (WD_EN && (state_r != ST_IDLE)) begin
                wd_r <= wd_r + 32'd1;
            end else begin
                wd_r <= 32'd0;
            end

            if (grant_data_s) begin
                m_req_r   <= 1'b1;
                m_we_r    <= d_wr_i;
                m_addr_r  <= d_addr_i;
                m_wdata_r <= d_wdata_i;
                m_wstrb_r <= d_wr_i ? d_wstrb_i : 4'hF;
            end else if (grant_fetch_s) begin
                m_req_r   <= 1'b1;
                m_we_r    <= 1'b0;
                m_addr_r  <= {if_addr_i[31:2], 2'b00};
                m_wstrb_r <= 4'hF;
            end else if (state_s == ST_IDLE) begin
                m_req_r <= 1'b0;
            end else begin
                m_req_r <= m_req_r;
            end
        end
    end

    assign m_req_o    = m_req_r;
    assign m_we_o     = m_we_r;
    assign m_addr_o   = m_addr_r;
    assign m_wdata_o  = m_wdata_r;
    assign m_wstrb_o  = m_wstrb_r;
    assign bus_err_o  = bus_err_r;
    assign if_rsp_o   = if_rsp_s;
    assign if_rdata_o = if_rdata_s;
    assign d_rsp_o    = d_rsp_s;
    assign d_rdata_o  = d_rdata_s;
    assign d_err_o    = d_err_s;

endmodule
